// File: rtl/ccd_scan_sequencer.sv
// Multi-line CCD scan scheduler: timed start pulses, progress/overrun/fault status.
// Define SCAN_OVERRUN_ABORT_EN to end the scan with err on the first overrun.
module ccd_scan_sequencer #(
  parameter int LINE_W      = 16,
  parameter int PERIOD_W    = 24,
  parameter int MIN_PERIOD  = 64,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                go_i,
  input  logic                abort_i,
  input  logic [LINE_W-1:0]   cfg_lines_i,
  input  logic [PERIOD_W-1:0] cfg_period_i,
  input  logic                cfg_mode_i,
  input  logic                ccd_busy_i,
  output logic                ccd_start_n_o,
  output logic                ccd_mode_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [LINE_W-1:0]   line_cnt_o,
  output logic [7:0]          overrun_cnt_o,
  output logic                err_o,
  output logic                aborted_o
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);
  localparam logic [PERIOD_W-1:0] MINP = PERIOD_W'(MIN_PERIOD);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WACK, S_WDONE, S_WPER, S_DRAIN, S_FIN
  } state_e;

  state_e              state_q;
  logic [LINE_W-1:0]   lines_q, line_cnt_q, line_inc;
  logic [PERIOD_W-1:0] per_q, per_d, per_last, cnt_q, cnt_d;
  logic [AW-1:0]       ack_q;
  logic [7:0]          ovr_cnt_q, ovr_inc;
  logic                ovr_q, dcnt_q;
  logic                start_n_q, mode_q, busy_q, done_q;
  logic                err_q, aborted_q;
  logic                at_last, in_wait, ovr_hit, can_abort;

  always_comb begin
    per_d = cfg_period_i;
    if (cfg_period_i < MINP) per_d = MINP;
  end

  // cnt_q reads k in the k-th cycle after a trigger; it saturates at P-1
  assign per_last  = per_q - PERIOD_W'(1);
  assign at_last   = cnt_q == per_last;
  assign cnt_d     = at_last ? cnt_q : cnt_q + PERIOD_W'(1);
  assign line_inc  = line_cnt_q + LINE_W'(1);
  assign ovr_inc   = (ovr_cnt_q == 8'hff) ? ovr_cnt_q : ovr_cnt_q + 8'd1;
  assign in_wait   = state_q == S_WACK || state_q == S_WDONE;
  assign ovr_hit   = in_wait && at_last && !ovr_q && line_inc != lines_q;
  assign can_abort = in_wait || state_q == S_TRIG || state_q == S_WPER;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      lines_q    <= '0;
      per_q      <= MINP;
      cnt_q      <= '0;
      ack_q      <= '0;
      line_cnt_q <= '0;
      ovr_cnt_q  <= '0;
      ovr_q      <= 1'b0;
      dcnt_q     <= 1'b0;
      start_n_q  <= 1'b1;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      start_n_q <= 1'b1;
      done_q    <= 1'b0;
      if (state_q != S_IDLE && state_q != S_TRIG) cnt_q <= cnt_d;
      if (ovr_hit) begin
        ovr_q     <= 1'b1;
        ovr_cnt_q <= ovr_inc;
      end
      if (can_abort && abort_i) begin
        aborted_q <= 1'b1;
        dcnt_q    <= 1'b0;
        if (ccd_busy_i) begin
          state_q <= S_DRAIN;
        end else begin
          state_q <= S_FIN;
          done_q  <= 1'b1;
        end
`ifdef SCAN_OVERRUN_ABORT_EN
      end else if (ovr_hit) begin
        err_q <= 1'b1;
        if (ccd_busy_i) begin
          state_q <= S_DRAIN;
          dcnt_q  <= 1'b1;
        end else begin
          if (state_q == S_WDONE) line_cnt_q <= line_inc;
          state_q <= S_FIN;
          done_q  <= 1'b1;
        end
`endif
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (go_i && !abort_i) begin
              lines_q    <= cfg_lines_i;
              per_q      <= per_d;
              mode_q     <= cfg_mode_i;
              line_cnt_q <= '0;
              ovr_cnt_q  <= '0;
              err_q      <= 1'b0;
              aborted_q  <= 1'b0;
              busy_q     <= 1'b1;
              if (cfg_lines_i != '0) begin
                state_q   <= S_TRIG;
                start_n_q <= 1'b0;
              end else begin
                state_q <= S_FIN;
                done_q  <= 1'b1;
              end
            end
          end
          S_TRIG: begin
            cnt_q   <= PERIOD_W'(1);
            ack_q   <= '0;
            ovr_q   <= 1'b0;
            state_q <= S_WACK;
          end
          S_WACK: begin
            if (ccd_busy_i) begin
              state_q <= S_WDONE;
            end else if (ack_q == ACK_LAST) begin
              err_q   <= 1'b1;
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              ack_q <= ack_q + AW'(1);
            end
          end
          S_WDONE: begin
            if (!ccd_busy_i) begin
              line_cnt_q <= line_inc;
              if (line_inc == lines_q) begin
                state_q <= S_FIN;
                done_q  <= 1'b1;
              end else if (at_last) begin
                state_q   <= S_TRIG;
                start_n_q <= 1'b0;
              end else begin
                state_q <= S_WPER;
              end
            end
          end
          S_WPER: begin
            if (at_last) begin
              state_q   <= S_TRIG;
              start_n_q <= 1'b0;
            end
          end
          S_DRAIN: begin
            if (!ccd_busy_i) begin
              if (dcnt_q) line_cnt_q <= line_inc;
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end
          end
          S_FIN: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ccd_start_n_o = start_n_q;
  assign ccd_mode_o    = mode_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign line_cnt_o    = line_cnt_q;
  assign overrun_cnt_o = ovr_cnt_q;
  assign err_o         = err_q;
  assign aborted_o     = aborted_q;

endmodule
